// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshaked data memory: FSM states, lane count and access checking.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic int unsigned lanes(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Misaligned (low byte-offset bits set) or word index past the end of the array.
  function automatic logic addr_err(input logic [63:0] addr,
                                    input int unsigned lb,
                                    input int unsigned depth);
    logic [63:0] mask;
    mask = (64'(1) << lb) - 64'(1);
    return ((addr & mask) != 64'(0)) || ((addr >> lb) >= 64'(depth));
  endfunction

endpackage

// File: rtl/dmem_hs_if.sv
// Request/response bus of the data memory; the memory is the slave, the MEM stage the master.
interface dmem_hs_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();
  import dmem_pkg::*;

  localparam int unsigned NL = lanes(DATA_W);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [NL-1:0]     req_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage: one byte-strobed write port, one combinational read port, no reset.
module dmem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned IW     = 7
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [IW-1:0]            waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [(DATA_W/8)-1:0]    wstrb_i,
  input  logic [IW-1:0]            raddr_i,
  output logic [DATA_W-1:0]        rdata_c_o
);

  localparam int unsigned NL = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int k = 0; k < NL; k++) begin
        if (wstrb_i[k]) mem_q[waddr_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
      end
    end
  end

  assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_hs.sv
// Handshaked data memory with alignment/range checking and a post-reset clear sweep.
// Define DMEM_PRELOAD_EN to have the sweep write PRELOAD_DATA at word PRELOAD_IDX.
module dmem_hs import dmem_pkg::*; #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DEPTH        = 128,
  parameter int unsigned PRELOAD_IDX  = 3,
  parameter int unsigned PRELOAD_DATA = 7
) (
  input logic       clk,
  input logic       rst,
  dmem_hs_if.slave  bus
);

  localparam int unsigned NL = lanes(DATA_W);
  localparam int unsigned LB = $clog2(NL);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DMEM_PRELOAD_EN
  localparam bit PRELOAD_ON = 1'b1;
`else
  localparam bit PRELOAD_ON = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [IW-1:0]     clr_idx_q, clr_idx_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              busy_q;

  logic              req_ready_c, accept_c, addr_err_c;
  logic [IW-1:0]     req_idx_c, mem_raddr_c, mem_waddr_c;
  logic [DATA_W-1:0] clr_word_c, mem_rdata_c, mem_wdata_c;
  logic [NL-1:0]     mem_wstrb_c;
  logic              mem_we_c;

  assign addr_err_c  = addr_err(64'(bus.req_addr), LB, DEPTH);
  assign req_idx_c   = IW'(bus.req_addr >> LB);
  assign mem_raddr_c = addr_err_c ? '0 : req_idx_c;
  assign clr_word_c  = (PRELOAD_ON && (32'(clr_idx_q) == PRELOAD_IDX)) ? DATA_W'(PRELOAD_DATA) : '0;

  dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IW(IW)) u_array (
    .clk       (clk),
    .we_i      (mem_we_c && rst),
    .waddr_i   (mem_waddr_c),
    .wdata_i   (mem_wdata_c),
    .wstrb_i   (mem_wstrb_c),
    .raddr_i   (mem_raddr_c),
    .rdata_c_o (mem_rdata_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_CLEAR;
      clr_idx_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= (state_d == ST_CLEAR);
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready_c = 1'b0;
    mem_we_c    = 1'b0;
    mem_waddr_c = '0;
    mem_wdata_c = '0;
    mem_wstrb_c = '0;

    case (state_q)
      ST_CLEAR: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = clr_idx_q;
        mem_wdata_c = clr_word_c;
        mem_wstrb_c = '1;
        if (clr_idx_q == IW'(DEPTH - 1)) begin
          clr_idx_d = '0;
          state_d   = ST_IDLE;
        end else begin
          clr_idx_d = clr_idx_q + IW'(1);
        end
      end
      ST_IDLE: req_ready_c = 1'b1;
      ST_RESP: begin
        req_ready_c = bus.rsp_ready;
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    // A new request overrides the drain-to-IDLE above, giving back-to-back responses.
    accept_c = req_ready_c && bus.req_valid;
    if (accept_c) begin
      state_d     = ST_RESP;
      rsp_valid_d = 1'b1;
      rsp_err_d   = addr_err_c;
      rsp_rdata_d = (bus.req_write || addr_err_c) ? '0 : mem_rdata_c;
      if (bus.req_write && !addr_err_c) begin
        mem_we_c    = 1'b1;
        mem_waddr_c = req_idx_c;
        mem_wdata_c = bus.req_wdata;
        mem_wstrb_c = bus.req_wstrb;
      end
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_dmem_hs.sv
// Scoreboard bench for dmem_hs: a behavioural memory model predicts each response at acceptance.
module tb_dmem_hs;
  import dmem_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned NL    = lanes(DW);
  localparam int unsigned LB    = $clog2(NL);

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_hs_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  dmem_hs #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rsp_t          exp_q[$];
  int            rsp_cyc[$];
  logic [DW-1:0] model [DEPTH];
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  logic [DW-1:0] last_rdata;
  logic          last_err;
  rsp_t          mon_e;
  logic          mon_err;
  int            mon_idx;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
`ifdef DMEM_PRELOAD_EN
    model[3] = DW'(7);
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Responses are checked before the same cycle's new request is predicted.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      model_clear();
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(1), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(mon_e.rdata));
          chk("rsp_err", 64'(bus.rsp_err), 64'(mon_e.err));
          last_rdata = bus.rsp_rdata;
          last_err   = bus.rsp_err;
          rsp_cyc.push_back(cyc);
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        mon_err = addr_err(64'(bus.req_addr), LB, DEPTH);
        mon_idx = int'(bus.req_addr >> LB);
        if (bus.req_write) begin
          if (!mon_err) begin
            for (int k = 0; k < NL; k++)
              if (bus.req_wstrb[k]) model[mon_idx][k*8 +: 8] = bus.req_wdata[k*8 +: 8];
          end
          exp_q.push_back('{rdata: '0, err: mon_err});
        end else begin
          exp_q.push_back('{rdata: (mon_err ? '0 : model[mon_idx]), err: mon_err});
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge with req_valid low.
  task automatic req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [NL-1:0] s);
    bit hs = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wstrb = s;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        hs = 1;
        break;
      end
    end
    if (!hs) chk("req_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic count_clear(input string tag);
    int n = 0;
    int busy_bad = 0;
    while (n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.req_ready) break;
      if (!bus.busy) busy_bad++;
    end
    chk({tag, "_cycles"}, 64'(n), 64'(128));
    chk({tag, "_busy_hi"}, 64'(busy_bad), 64'(0));
    chk({tag, "_busy_lo"}, 64'(bus.busy), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    bus.rsp_ready = 1'b1;

    // Reset state and clear duration
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(1));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    count_clear("clr1");
    req(1'b0, 32'h0, '0, '0);
    wait_drain();
    chk("t1_rd0", 64'(last_rdata), 64'(0));
`ifdef DMEM_PRELOAD_EN
    req(1'b0, 32'hC, '0, '0);
    wait_drain();
    chk("t1_preload", 64'(last_rdata), 64'(7));
`endif

    // Byte-strobed writes
    req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    req(1'b1, 32'h10, 32'h000000AA, 4'h1);
    req(1'b0, 32'h10, '0, '0);
    wait_drain();
    chk("t2_rdata", 64'(last_rdata), 64'(32'hDEADBEAA));
    chk("t2_err", 64'(last_err), 64'(0));

    // Zero-strobe write is a legal no-op
    req(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
    wait_drain();
    chk("wstrb0_err", 64'(last_err), 64'(0));
    req(1'b0, 32'h10, '0, '0);
    wait_drain();
    chk("wstrb0_rd", 64'(last_rdata), 64'(32'hDEADBEAA));

    // Misaligned and out-of-range accesses
    req(1'b0, 32'h6, '0, '0);
    wait_drain();
    chk("t3_mis_err", 64'(last_err), 64'(1));
    chk("t3_mis_rdata", 64'(last_rdata), 64'(0));
    req(1'b0, 32'h200, '0, '0);
    wait_drain();
    chk("t3_oor_err", 64'(last_err), 64'(1));
    chk("t3_oor_rdata", 64'(last_rdata), 64'(0));
    req(1'b1, 32'h200, 32'h55, 4'hF);
    req(1'b1, 32'h13, 32'h77, 4'hF);
    for (int i = 0; i < DEPTH; i++) req(1'b0, AW'(i * 4), '0, '0);
    wait_drain();

    // Backpressure
    bus.rsp_ready = 1'b0;
    req(1'b0, 32'h10, '0, '0);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h20;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t4_rsp_valid", 64'(bus.rsp_valid), 64'(1));
      chk("t4_rdata", 64'(bus.rsp_rdata), 64'(32'hDEADBEAA));
      chk("t4_err", 64'(bus.rsp_err), 64'(0));
      chk("t4_req_ready", 64'(bus.req_ready), 64'(0));
      chk("t4_no_accept", 64'(exp_q.size()), 64'(1));
    end
    bus.rsp_ready = 1'b1;
    req(1'b0, 32'h20, '0, '0);
    wait_drain();

    // Back-to-back write then read
    rsp_cyc.delete();
    req(1'b1, 32'h20, 32'h1234, 4'hF);
    req(1'b0, 32'h20, '0, '0);
    wait_drain();
    chk("t5_count", 64'(rsp_cyc.size()), 64'(2));
    if (rsp_cyc.size() == 2) chk("t5_consec", 64'(rsp_cyc[1] - rsp_cyc[0]), 64'(1));
    chk("t5_rdata", 64'(last_rdata), 64'(32'h1234));

    // Reset while a response is pending
    bus.rsp_ready = 1'b0;
    req(1'b0, 32'h20, '0, '0);
    chk("t6_pending", 64'(bus.rsp_valid), 64'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("t6_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("t6_busy", 64'(bus.busy), 64'(1));
    chk("t6_req_ready", 64'(bus.req_ready), 64'(0));
    count_clear("clr2");
    bus.rsp_ready = 1'b1;
    req(1'b0, 32'h20, '0, '0);
    req(1'b0, 32'h10, '0, '0);
    wait_drain();
    chk("t6_cleared", 64'(last_rdata), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
